conv_fmap_writer: RTL and testbench
===================================

Name: conv_fmap_writer

Overview:
- Write-side counterpart of the pooling reader on the conv feature-map RAM.
- Accepts a stream of convolution results with a valid/ready handshake. The stream is pixel-major: all NUM_FILTERS results for one window position arrive consecutively, in raster window order.
- Applies optional ReLU and writes each result to the filter-major RAM layout, addr = f*OUT_H*OUT_W + r*OUT_W + c.
- Pulses done once the full frame is stored, so pooling can be started from it.

Parameters:
- DATA_WIDTH, 32, width of a conv result and a RAM word (signed).
- IMG_HEIGHT, 28, input image height; OUT_H = IMG_HEIGHT-2.
- IMG_WIDTH, 28, input image width; OUT_W = IMG_WIDTH-2.
- NUM_FILTERS, 8, number of filters per window position.
- RELU_EN, 1, 1 = clamp negative results to 0; 0 = pass unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  arms a new frame; sampled only in IDLE.
- valid_in  in  1  data_in holds a conv result.
- data_in  in  DATA_WIDTH  signed conv result.
- ready_in  out  1  block accepts data; combinational, equals (state==RUN).
- ram_we  out  1  RAM write enable, one-cycle pulse per word.
- ram_addr  out  32  RAM word address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- done  out  1  one-cycle pulse after the last word is written.
- busy  out  1  high in RUN and FINISH.
- overflow  out  1  sticky: valid_in was seen while in IDLE; cleared by accepted start.

Behaviour:
- Reset (async, any time, including mid-frame):
  - state=IDLE; f, r, c = 0.
  - ram_we, ram_addr, ram_wdata, done, overflow = 0.
  - busy=0 and ready_in=0 immediately, with no clock required.
  - Words already written are not undone.
- States:
  - IDLE: start=1 clears counters and overflow, next state RUN.
  - RUN: ready_in=1. Accept on valid_in && ready_in.
  - FINISH: one cycle; done=1; next state IDLE.
- Accept at edge E:
  - ram_we=1, ram_addr=f*OUT_H*OUT_W + r*OUT_W + c, ram_wdata=relu(data_in), all registered, visible in the cycle after E.
  - ram_we=0 in every cycle without a prior accept.
- Counter order:
  - f increments fastest. At f==NUM_FILTERS-1: f=0, c++.
  - At c==OUT_W-1: c=0, r++.
- Last accept (f,r,c = NUM_FILTERS-1, OUT_H-1, OUT_W-1):
  - state goes RUN->FINISH at that edge.
  - The last write is visible during the FINISH cycle.
  - done is high in the cycle after FINISH, i.e. one cycle after the last ram_we.
  - done coincides with the return to IDLE; the FINISH state drives done through its registered output.
  - Total writes per frame = NUM_FILTERS*OUT_H*OUT_W (5408 at defaults); last address 5407.
- No accept in a cycle -> counters hold. Gaps in valid_in are arbitrary.
- valid_in in IDLE: no write, overflow<=1 (sticky). valid_in during FINISH: ignored, no flag.
- start outside IDLE, and start in the FINISH cycle, are ignored.
- start and valid_in together in IDLE: start wins, overflow cleared, data not accepted (ready_in was 0).
- Arithmetic:
  - ReLU uses signed compare: data_in[DATA_WIDTH-1]==1 -> 0 when RELU_EN=1.
  - Address computed at full 32-bit width; no wrap within a frame.
- Counter widths: $clog2 of each bound, minimum 1 bit.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle, no clk edge -> ram_we=0, done=0, busy=0, ready_in=0, ram_addr=0 immediately.
- Address order: start, feed data 1..9 continuously -> writes (addr,data) = (0,1), (676,2), (1352,3) ... (4732,8), then (1,9). Word index 208 -> addr 26 (r1,c0,f0).
- Full frame at defaults, valid_in held high:
  - exactly 5408 ram_we pulses; last addr 5407;
  - ready_in low from the cycle after the last accept;
  - done pulses once, one cycle after the final write; busy falls with done.
- ReLU, RELU_EN=1: data 0xFFFFFFFB -> wdata 0; 0x7FFFFFFF -> 0x7FFFFFFF. With RELU_EN=0: 0xFFFFFFFB passes unchanged.
- Gaps and overflow:
  - valid_in pseudo-random 50% during the frame -> address sequence identical to the continuous case.
  - valid_in after done -> no write, overflow=1; next start clears it.
- Async reset mid-frame after 100 accepts -> outputs cleared at once. New start -> first write at addr 0 with f,r,c restarted.

Source files
------------

// File: rtl/conv_fmap_writer.sv
// -----------------------------------------------------------------------------
// conv_fmap_writer
//
// Write side of the conv feature-map RAM. It takes a pixel-major stream of
// convolution results: all NUM_FILTERS results for one window position arrive
// back to back, and window positions arrive in raster order. Each result goes
// through an optional ReLU. It is then stored in the filter-major layout that
// the pooling reader expects:
//    addr = f*OUT_H*OUT_W + r*OUT_W + c
// A one-cycle done pulse follows the last write, so pooling can start on a
// complete frame.
//
// Ports
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    start      in   arms a new frame (honoured only in IDLE)
//    valid_in   in   data_in holds a conv result
//    data_in    in   signed conv result, DATA_WIDTH bits
//    ready_in   out  accepting results (high only in RUN, combinational)
//    ram_we     out  one-cycle write strobe per stored word
//    ram_addr   out  32-bit RAM word address
//    ram_wdata  out  RAM write data (after ReLU)
//    done       out  one-cycle pulse, one cycle after the final write
//    busy       out  high while in RUN or FINISH
//    overflow   out  sticky: valid_in seen while IDLE; cleared by start
// -----------------------------------------------------------------------------
module conv_fmap_writer #(
   parameter int DATA_WIDTH  = 32,
   parameter int IMG_HEIGHT  = 28,
   parameter int IMG_WIDTH   = 28,
   parameter int NUM_FILTERS = 8,
   parameter bit RELU_EN     = 1'b1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         valid_in,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   output logic                         ready_in,
   output logic                         ram_we,
   output logic        [31:0]           ram_addr,
   output logic signed [DATA_WIDTH-1:0] ram_wdata,
   output logic                         done,
   output logic                         busy,
   output logic                         overflow
);

   localparam int OUT_H = IMG_HEIGHT - 2;
   localparam int OUT_W = IMG_WIDTH - 2;
   localparam int PLANE = OUT_H * OUT_W;

   localparam int F_W = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   localparam int R_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int C_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } state_e;

   state_e                       state_q, state_d;
   logic         [F_W-1:0]       f_q, f_d;
   logic         [R_W-1:0]       r_q, r_d;
   logic         [C_W-1:0]       c_q, c_d;
   logic                         we_q, we_d;
   logic         [31:0]          addr_q, addr_d;
   logic signed [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                         done_q, done_d;
   logic                         ovf_q, ovf_d;

   logic                         accept;
   logic                         last_f, last_r, last_c;
   logic         [31:0]          addr_calc;
   logic signed [DATA_WIDTH-1:0] relu_data;

   assign accept = (state_q == S_RUN) && valid_in;
   assign last_f = (f_q == F_W'(NUM_FILTERS - 1));
   assign last_r = (r_q == R_W'(OUT_H - 1));
   assign last_c = (c_q == C_W'(OUT_W - 1));

   // The address is computed at full 32-bit width so a frame never wraps.
   assign addr_calc = 32'(f_q) * 32'(PLANE) + 32'(r_q) * 32'(OUT_W) + 32'(c_q);

   // The sign bit alone decides the ReLU clamp.
   assign relu_data = (RELU_EN && data_in[DATA_WIDTH-1]) ? '0 : data_in;

   // NOTE: every signal written here gets a default first. That way no path can
   // leave a signal unassigned, and no latch is inferred.
   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      r_d     = r_q;
      c_d     = c_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      ovf_d   = ovf_q;
      // done is registered from the FINISH state. The pulse therefore lands on
      // the cycle after FINISH, together with the return to IDLE.
      done_d  = (state_q == S_FINISH);

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               f_d     = '0;
               r_d     = '0;
               c_d     = '0;
               ovf_d   = 1'b0;
            end else if (valid_in) begin
               ovf_d = 1'b1;
            end
         end
         S_RUN: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = addr_calc;
               wdata_d = relu_data;
               // The filter index moves fastest, then column, then row.
               if (last_f) begin
                  f_d = '0;
                  if (last_c) begin
                     c_d = '0;
                     r_d = last_r ? '0 : r_q + 1'b1;
                  end else begin
                     c_d = c_q + 1'b1;
                  end
               end else begin
                  f_d = f_q + 1'b1;
               end
               if (last_f && last_r && last_c) begin
                  state_d = S_FINISH;
               end
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only. All registers
   // then update together at the edge, whatever order they are written in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         f_q     <= '0;
         r_q     <= '0;
         c_q     <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         r_q     <= r_d;
         c_q     <= c_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   // ready_in and busy are decoded straight from the state register. Reset
   // therefore drops them at once, without waiting for a clock edge.
   assign ready_in  = (state_q == S_RUN);
   assign busy      = (state_q != S_IDLE);
   assign ram_we    = we_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;
   assign done      = done_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_conv_fmap_writer.sv
// -----------------------------------------------------------------------------
// tb_conv_fmap_writer
//
// Directed bench for conv_fmap_writer. The main instance uses the default
// parameters with ReLU enabled. A second, small instance (4x4 image, 2 filters,
// ReLU disabled) checks pass-through of negative data and a compact frame.
// -----------------------------------------------------------------------------
module tb_conv_fmap_writer;

   localparam int NF    = 8;
   localparam int OW    = 26;
   localparam int OH    = 26;
   localparam int PLANE = OH * OW;
   localparam int WORDS = NF * PLANE;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        start, valid_in;
   logic [31:0] data_in;
   logic        ready_in, ram_we, done, busy, overflow;
   logic [31:0] ram_addr, ram_wdata;

   logic        b_start, b_valid;
   logic [31:0] b_data;
   logic        b_ready, b_we, b_done, b_busy, b_ovf;
   logic [31:0] b_addr, b_wdata;

   int checks = 0;
   int errors = 0;

   int first_addr_tbl [9] = '{0, 676, 1352, 2028, 2704, 3380, 4056, 4732, 1};
   int b_addr_tbl     [8] = '{0, 4, 1, 5, 2, 6, 3, 7};

   always #5 clk = ~clk;

   conv_fmap_writer #(
      .DATA_WIDTH(32), .IMG_HEIGHT(28), .IMG_WIDTH(28), .NUM_FILTERS(8), .RELU_EN(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in), .data_in(data_in),
      .ready_in(ready_in), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .done(done), .busy(busy), .overflow(overflow)
   );

   conv_fmap_writer #(
      .DATA_WIDTH(32), .IMG_HEIGHT(4), .IMG_WIDTH(4), .NUM_FILTERS(2), .RELU_EN(1'b0)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .valid_in(b_valid), .data_in(b_data),
      .ready_in(b_ready), .ram_we(b_we), .ram_addr(b_addr), .ram_wdata(b_wdata),
      .done(b_done), .busy(b_busy), .overflow(b_ovf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Filter-major address of the k-th word of the pixel-major stream.
   function automatic logic [31:0] exp_addr(input int k);
      int f, pix, r, c;
      f   = k % NF;
      pix = k / NF;
      r   = pix / OW;
      c   = pix % OW;
      return 32'(f * PLANE + r * OW + c);
   endfunction

   // Stream data: ascending values, with a few ReLU corner cases mixed in.
   function automatic logic [31:0] stim(input int k);
      case (k)
         10:      return 32'hFFFF_FFFB;
         11:      return 32'h7FFF_FFFF;
         12:      return 32'h8000_0000;
         default: return 32'(k + 1);
      endcase
   endfunction

   function automatic logic [31:0] relu_ref(input logic [31:0] d);
      return d[31] ? 32'd0 : d;
   endfunction

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_ready", {31'd0, ready_in}, 32'd1);
      check("start_busy",  {31'd0, busy},     32'd1);
   endtask

   // Stream one full frame and check every write, the end-of-frame handshake
   // and the done pulse.
   task automatic run_frame(input bit gaps);
      int  sent, writes, cyc, last_we_cyc, done_cyc, done_cnt;
      bit  acc;
      logic [31:0] last_addr;
      sent = 0; writes = 0; cyc = 0; last_we_cyc = -10; done_cyc = -1; done_cnt = 0;
      last_addr = '0;
      data_in  = stim(0);
      valid_in = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      while (done_cnt == 0 && cyc < 30000) begin
         acc = valid_in && ready_in;
         tick();
         cyc++;
         if (acc) sent++;
         if (ram_we) begin
            check("addr_seq",  ram_addr,  exp_addr(writes));
            check("wdata_seq", ram_wdata, relu_ref(stim(writes)));
            if (writes < 9) check("addr_first9", ram_addr, 32'(first_addr_tbl[writes]));
            if (writes == 208) check("addr_word208", ram_addr, 32'd26);
            if (writes == 10) check("relu_neg", ram_wdata, 32'd0);
            if (writes == 11) check("relu_max", ram_wdata, 32'h7FFF_FFFF);
            last_addr   = ram_addr;
            last_we_cyc = cyc;
            writes++;
         end
         if (acc && sent == WORDS) begin
            check("ready_low_after_last", {31'd0, ready_in}, 32'd0);
            check("busy_in_finish",       {31'd0, busy},     32'd1);
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("busy_falls_with_done", {31'd0, busy}, 32'd0);
         end
         data_in = stim(sent);
         // Once the frame is complete, valid_in stays high through FINISH,
         // where it must be ignored.
         if (sent < WORDS) valid_in = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         else              valid_in = 1'b1;
      end
      valid_in = 1'b0;
      check("done_seen",      32'(done_cnt),    32'd1);
      check("write_count",    32'(writes),      32'(WORDS));
      check("last_addr",      last_addr,        32'd5407);
      check("done_after_we",  32'(done_cyc - last_we_cyc), 32'd1);
      check("finish_valid_no_ovf", {31'd0, overflow}, 32'd0);
      tick();
      check("done_one_cycle", {31'd0, done},   32'd0);
      check("idle_no_we",     {31'd0, ram_we}, 32'd0);
   endtask

   initial begin
      int  sent, guard;
      bit  acc;
      start = 1'b0; valid_in = 1'b0; data_in = '0;
      b_start = 1'b0; b_valid = 1'b0; b_data = '0;
      rst_n = 1'b1;

      // Reset with no clock edge: the outputs must clear immediately.
      #2 rst_n = 1'b0;
      #1;
      check("rst_we",    {31'd0, ram_we},   32'd0);
      check("rst_done",  {31'd0, done},     32'd0);
      check("rst_busy",  {31'd0, busy},     32'd0);
      check("rst_ready", {31'd0, ready_in}, 32'd0);
      check("rst_addr",  ram_addr,          32'd0);
      check("rst_ovf",   {31'd0, overflow}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Frame 1: continuous stream. Frame 2: about 50% gaps, same address order.
      do_start();
      run_frame(1'b0);
      do_start();
      run_frame(1'b1);

      // valid_in while IDLE: no write, and overflow becomes sticky.
      valid_in = 1'b1;
      data_in  = 32'h1234;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("idle_valid_no_we", {31'd0, ram_we},   32'd0);
         check("idle_valid_ovf",   {31'd0, overflow}, 32'd1);
      end

      // start together with valid_in: start wins, overflow clears, no write.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_clears_ovf", {31'd0, overflow}, 32'd0);
      check("start_no_accept",  {31'd0, ram_we},   32'd0);
      check("start_run",        {31'd0, ready_in}, 32'd1);

      // Accept 100 words, then apply reset mid-cycle.
      sent = 0; guard = 0;
      data_in = stim(0);
      while (sent < 100 && guard < 300) begin
         acc = valid_in && ready_in;
         tick();
         guard++;
         if (acc) sent++;
         data_in = stim(sent);
      end
      check("mid_accepts",    32'(sent),        32'd100);
      check("mid_we_before",  {31'd0, ram_we},  32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_we",    {31'd0, ram_we},   32'd0);
      check("mid_rst_done",  {31'd0, done},     32'd0);
      check("mid_rst_busy",  {31'd0, busy},     32'd0);
      check("mid_rst_ready", {31'd0, ready_in}, 32'd0);
      check("mid_rst_addr",  ram_addr,          32'd0);
      check("mid_rst_wdata", ram_wdata,         32'd0);
      valid_in = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // After reset the counters restart, and the first writes go to 0 and 676.
      do_start();
      valid_in = 1'b1;
      data_in  = 32'h55;
      tick();
      check("restart_we0",    {31'd0, ram_we}, 32'd1);
      check("restart_addr0",  ram_addr,        32'd0);
      check("restart_data0",  ram_wdata,       32'h55);
      data_in = 32'h66;
      tick();
      valid_in = 1'b0;
      check("restart_addr1",  ram_addr,        32'd676);
      check("restart_data1",  ram_wdata,       32'h66);
      tick();
      check("restart_gap_we", {31'd0, ram_we}, 32'd0);

      // Small instance, ReLU disabled: a whole 8-word frame.
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      b_valid = 1'b1;
      b_data  = 32'hFFFF_FFFB;
      for (int k = 0; k < 8; k++) begin
         tick();
         check("b_we",   {31'd0, b_we}, 32'd1);
         check("b_addr", b_addr,        32'(b_addr_tbl[k]));
         check("b_data", b_wdata,       (k == 0) ? 32'hFFFF_FFFB : 32'(k + 1));
         b_data = 32'(k + 2);
      end
      b_valid = 1'b0;
      check("b_ready_low", {31'd0, b_ready}, 32'd0);
      tick();
      check("b_done", {31'd0, b_done}, 32'd1);
      check("b_busy", {31'd0, b_busy}, 32'd0);
      check("b_ovf",  {31'd0, b_ovf},  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
